// File: rtl/stream_chk_pkg.sv
// rtl/stream_chk_pkg.sv - shared FSM state type and ramp mode constants for stream_chk
package stream_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DE = 2'd1,
    ACTIVE  = 2'd2,
    BLANK   = 2'd3
  } state_e;

  localparam logic MODE_H_RAMP = 1'b0;
  localparam logic MODE_V_RAMP = 1'b1;

endpackage

// File: rtl/stream_chk_pgen.sv
// rtl/stream_chk_pgen.sv - expected pixel generator (H ramp / V ramp) for stream_chk
module stream_chk_pgen
  import stream_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rstx,
  input  logic       hd_i,
  input  logic       pix_i,
  input  logic       first_i,
  input  logic       done_i,
  input  logic       locked_i,
  input  logic       mode_i,
  input  logic [7:0] d_i,
  output logic [7:0] exp_o,
  output logic       exp_vld_o
);

  logic       mode_q, mode_d;
  logic [7:0] h_q, h_d;
  logic [7:0] line_q, line_d;
  logic [7:0] ref_q, ref_d;
  logic       ref_vld_q, ref_vld_d;

  always_comb begin
    mode_d    = mode_q;
    h_d       = h_q;
    line_d    = line_q;
    ref_d     = ref_q;
    ref_vld_d = ref_vld_q;
    if (first_i) line_d = d_i;
    if (done_i && locked_i && (mode_q == MODE_V_RAMP)) begin
      ref_d     = line_q;
      ref_vld_d = 1'b1;
    end
    // A mode switch invalidates the V reference even if a line completes in the same cycle
    if (hd_i) begin
      mode_d = mode_i;
      h_d    = 8'd0;
      if (mode_i != mode_q) ref_vld_d = 1'b0;
    end else if (pix_i) begin
      h_d = h_q + 8'd1;
    end
  end

  always_comb begin
    exp_o     = line_q;
    exp_vld_o = 1'b1;
    if (mode_q == MODE_H_RAMP) begin
      exp_o = h_q;
    end else if (first_i) begin
      exp_o     = ref_q + 8'd1;
      exp_vld_o = ref_vld_q;
    end
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      mode_q    <= MODE_H_RAMP;
      h_q       <= 8'd0;
      line_q    <= 8'd0;
      ref_q     <= 8'd0;
      ref_vld_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      h_q       <= h_d;
      line_q    <= line_d;
      ref_q     <= ref_d;
      ref_vld_q <= ref_vld_d;
    end
  end

endmodule

// File: rtl/stream_chk.sv
// rtl/stream_chk.sv - video line stream checker: lock, line length, ramp data and sync errors
// Optional err_cnt output enabled by STREAM_CHK_ERRCNT_EN.
module stream_chk
  import stream_chk_pkg::*;
#(
  parameter int PIX_W   = 12,
  parameter int EXP_PIX = 640
) (
  input  logic             clk,
  input  logic             rstx,
  input  logic             hd,
  input  logic             de,
  input  logic [7:0]       d,
  input  logic             mode_sel,
  input  logic             err_clr,
  output logic             locked,
  output logic [PIX_W-1:0] pix_cnt,
  output logic [PIX_W-1:0] line_cnt,
  output logic             err_data,
  output logic             err_len,
  output logic             err_sync
`ifdef STREAM_CHK_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [PIX_W-1:0] CNT_MAX = '1;
  localparam logic [PIX_W-1:0] CNT_ONE = PIX_W'(1);
  localparam logic [PIX_W-1:0] EXP_LEN = PIX_W'(EXP_PIX);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0] line_cnt_q, line_cnt_d;
  logic             locked_q, locked_d;
  logic             err_data_q, err_data_d;
  logic             err_len_q, err_len_d;
  logic             err_sync_q, err_sync_d;

  logic             first_px, pix, line_end;
  logic             ev_data, ev_len, ev_sync;
  logic [7:0]       exp_px;
  logic             exp_vld;

  assign first_px = (state_q == WAIT_DE) && de && !hd;
  assign pix      = first_px || ((state_q == ACTIVE) && de && !hd);
  assign line_end = (state_q == ACTIVE) && !de;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hd) state_d = WAIT_DE;
      WAIT_DE: if (!hd && de) state_d = ACTIVE;
      ACTIVE:  if (hd) state_d = WAIT_DE;
               else if (!de) state_d = BLANK;
      BLANK:   if (hd) state_d = WAIT_DE;
      default: state_d = IDLE;
    endcase
  end

  // The line that acquires lock is counted but not length/data checked
  always_comb begin
    cnt_d      = cnt_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    locked_d   = locked_q;
    ev_len     = 1'b0;
    if (first_px) begin
      cnt_d = CNT_ONE;
    end else if (pix) begin
      if (cnt_q == CNT_MAX) ev_len = locked_q;
      else cnt_d = cnt_q + CNT_ONE;
    end
    if (line_end) begin
      pix_cnt_d  = cnt_q;
      line_cnt_d = line_cnt_q + CNT_ONE;
      locked_d   = 1'b1;
      if (locked_q && (cnt_q != EXP_LEN)) ev_len = 1'b1;
    end
  end

  assign ev_data = locked_q && pix && exp_vld && (d != exp_px);
  assign ev_sync = (hd && de) || ((state_q == BLANK) && de)
                || ((state_q == WAIT_DE) && hd && !de);

  assign err_data_d = (err_data_q && !err_clr) || ev_data;
  assign err_len_d  = (err_len_q  && !err_clr) || ev_len;
  assign err_sync_d = (err_sync_q && !err_clr) || ev_sync;

  stream_chk_pgen u_pgen (
    .clk       (clk),
    .rstx      (rstx),
    .hd_i      (hd),
    .pix_i     (pix),
    .first_i   (first_px),
    .done_i    (line_end),
    .locked_i  (locked_q),
    .mode_i    (mode_sel),
    .d_i       (d),
    .exp_o     (exp_px),
    .exp_vld_o (exp_vld)
  );

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_data_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      locked_q   <= locked_d;
      err_data_q <= err_data_d;
      err_len_q  <= err_len_d;
      err_sync_q <= err_sync_d;
    end
  end

  assign locked   = locked_q;
  assign pix_cnt  = pix_cnt_q;
  assign line_cnt = line_cnt_q;
  assign err_data = err_data_q;
  assign err_len  = err_len_q;
  assign err_sync = err_sync_q;

`ifdef STREAM_CHK_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_clr ? 16'd0 : err_cnt_q;
    if ((ev_data || ev_len || ev_sync) && (err_cnt_d != 16'hFFFF))
      err_cnt_d = err_cnt_d + 16'd1;
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) err_cnt_q <= 16'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_stream_chk.sv
// tb/tb_stream_chk.sv - self-checking bench for stream_chk with a line-level reference model
module tb_stream_chk;

  localparam int PIX_W   = 12;
  localparam int EXP_PIX = 640;
  localparam int CMAX    = (1 << PIX_W) - 1;

  logic             clk = 1'b0;
  logic             rstx = 1'b0;
  logic             hd = 1'b0;
  logic             de = 1'b0;
  logic [7:0]       d = 8'd0;
  logic             mode_sel = 1'b0;
  logic             err_clr = 1'b0;
  logic             locked, err_data, err_len, err_sync;
  logic [PIX_W-1:0] pix_cnt, line_cnt;
`ifdef STREAM_CHK_ERRCNT_EN
  logic [15:0]      err_cnt;
`endif

  stream_chk #(.PIX_W(PIX_W), .EXP_PIX(EXP_PIX)) dut (
    .clk      (clk),
    .rstx     (rstx),
    .hd       (hd),
    .de       (de),
    .d        (d),
    .mode_sel (mode_sel),
    .err_clr  (err_clr),
    .locked   (locked),
    .pix_cnt  (pix_cnt),
    .line_cnt (line_cnt),
    .err_data (err_data),
    .err_len  (err_len),
    .err_sync (err_sync)
`ifdef STREAM_CHK_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Line-level model state
  bit m_locked, m_data, m_len, m_sync, m_vmode, m_ref_vld;
  int m_line, m_pix, m_ref;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_data = 0; m_len = 0; m_sync = 0;
    m_vmode = 0; m_ref_vld = 0; m_line = 0; m_pix = 0; m_ref = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"},   32'(locked),   32'(m_locked));
    chk({tag, ".pix_cnt"},  32'(pix_cnt),  32'(m_pix));
    chk({tag, ".line_cnt"}, 32'(line_cnt), 32'(m_line % (CMAX + 1)));
    chk({tag, ".err_data"}, 32'(err_data), 32'(m_data));
    chk({tag, ".err_len"},  32'(err_len),  32'(m_len));
    chk({tag, ".err_sync"}, 32'(err_sync), 32'(m_sync));
  endtask

  task automatic clear_flags(input string tag);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_data = 0; m_len = 0; m_sync = 0;
    check_all(tag);
  endtask

  // One full line: hd, gap, n DE pixels, blank. Optional single bad pixel and err_clr pair.
  task automatic send_line(input string tag, input int n, input bit vm, input logic [7:0] vv,
                           input int bad_idx, input logic [7:0] bad_v, input int clr_idx);
    bit         first_err, bad_err;
    logic [7:0] ideal, bidx8;
    int         pc;
    if (vm != m_vmode) m_ref_vld = 0;
    m_vmode = vm;
    bidx8   = 8'(bad_idx);
    if (!vm) begin
      bad_err   = (bad_idx >= 0) && (bad_v != bidx8);
      first_err = (bad_idx == 0) && bad_err;
    end else begin
      bad_err   = (bad_idx > 0) && (bad_v != vv);
      first_err = m_ref_vld && (vv != 8'(m_ref + 1));
    end
    @(negedge clk); mode_sel = vm; hd = 1'b1;
    @(negedge clk); hd = 1'b0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == 1)
        chk({tag, ".first_px_err_data"}, 32'(err_data), 32'(m_data || (m_locked && first_err)));
      if (clr_idx >= 0 && i == clr_idx + 1)
        chk({tag, ".clr_same_cycle"}, 32'(err_data), 32'(m_locked && bad_err));
      if (clr_idx >= 0 && i == clr_idx + 2)
        chk({tag, ".clr_alone"}, 32'(err_data), 32'd0);
      err_clr = (clr_idx >= 0) && (i == clr_idx || i == clr_idx + 1);
      ideal   = vm ? vv : 8'(i);
      de = 1'b1;
      d  = (i == bad_idx) ? bad_v : ideal;
      @(negedge clk);
    end
    de = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    if (clr_idx >= 0) begin
      m_data = 0; m_len = 0; m_sync = 0;
    end else if (m_locked && (first_err || bad_err)) begin
      m_data = 1;
    end
    pc = (n > CMAX) ? CMAX : n;
    if (m_locked && pc != EXP_PIX) m_len = 1;
    if (m_locked && vm) begin m_ref = int'(vv); m_ref_vld = 1; end
    m_pix = pc; m_line++; m_locked = 1;
    check_all(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vv, bv;
    bit         vm;
    int         n, bi;

    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rstx = 1'b1;

    for (int k = 0; k < 4; k++) send_line("h_clean", EXP_PIX, 1'b0, 8'd0, -1, 8'd0, -1);

    send_line("v10", EXP_PIX, 1'b1, 8'd10, -1, 8'd0, -1);
    send_line("v11", EXP_PIX, 1'b1, 8'd11, -1, 8'd0, -1);
    send_line("v12", EXP_PIX, 1'b1, 8'd12, -1, 8'd0, -1);
    send_line("v14", EXP_PIX, 1'b1, 8'd14, -1, 8'd0, -1);
    clear_flags("clr1");

    send_line("short", EXP_PIX - 1, 1'b0, 8'd0, -1, 8'd0, -1);
    clear_flags("clr2");

    // hd arrives while de is still high: partial line discarded
    if (m_vmode) m_ref_vld = 0;
    m_vmode = 0;
    @(negedge clk); mode_sel = 1'b0; hd = 1'b1;
    @(negedge clk); hd = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin de = 1'b1; d = 8'(i); @(negedge clk); end
    hd = 1'b1; de = 1'b1; d = 8'd20;
    @(negedge clk); hd = 1'b0; de = 1'b0;
    repeat (3) @(negedge clk);
    m_sync = 1;
    check_all("sync");
    send_line("after_sync", EXP_PIX, 1'b0, 8'd0, -1, 8'd0, -1);
    clear_flags("clr3");

    send_line("clr_race", EXP_PIX, 1'b0, 8'd0, 5, 8'h55, 5);

    send_line("saturate", CMAX + 5, 1'b0, 8'd0, -1, 8'd0, -1);
    clear_flags("clr4");

    for (int k = 0; k < 12; k++) begin
      vm = ($urandom_range(0, 3) == 0) ? ~m_vmode : m_vmode;
      case ($urandom_range(0, 7))
        0:       n = EXP_PIX - 1;
        1:       n = EXP_PIX + 1;
        default: n = EXP_PIX;
      endcase
      vv = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(m_ref + 1);
      bi = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : -1;
      bv = 8'($urandom);
      send_line("rand", n, vm, vv, bi, bv, -1);
      if ($urandom_range(0, 2) == 0) clear_flags("rand_clr");
    end

    // Reset asserted and released in the middle of a line
    @(negedge clk); mode_sel = 1'b0; hd = 1'b1;
    @(negedge clk); hd = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin de = 1'b1; d = 8'(i); @(negedge clk); end
    #2 rstx = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    for (int i = 100; i < 200; i++) begin
      if (i == 101) rstx = 1'b1;
      de = 1'b1; d = 8'(i); @(negedge clk);
    end
    de = 1'b0;
    repeat (3) @(negedge clk);
    check_all("rst_partial");
    send_line("relock", EXP_PIX, 1'b0, 8'd0, -1, 8'd0, -1);
    send_line("relock2", EXP_PIX, 1'b0, 8'd0, -1, 8'd0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_chk.md
STREAM_CHK -- requirements
Module: stream_chk

Interface
REQ-001 SHALL provide parameter PIX_W, default 12, meaning width of pixel/line counters.
REQ-002 SHALL provide parameter EXP_PIX, default 640, meaning expected DE-high pixels per line.
REQ-003 SHALL provide ports: clk  in  1  sole clock; rstx  in  1  asynchronous active-low reset.
REQ-004 SHALL provide ports: hd  in  1  one-cycle line-start pulse; de  in  1  active pixel enable; d  in  8  pixel data; mode_sel  in  1  0=H ramp, 1=V ramp.
REQ-005 SHALL provide ports: locked  out  1  first full line seen; pix_cnt  out  PIX_W  DE count of last completed line; line_cnt  out  PIX_W  completed lines since lock.
REQ-006 SHALL provide ports: err_data  out  1  sticky pattern mismatch; err_len  out  1  sticky line-length mismatch; err_sync  out  1  sticky protocol violation; err_clr  in  1  clears sticky flags.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT_DE, ACTIVE, BLANK.
REQ-008 IDLE->WAIT_DE on hd; WAIT_DE->ACTIVE on de; ACTIVE->BLANK on de falling; BLANK->WAIT_DE on hd.
REQ-009 SHALL count DE-high cycles per line; on ACTIVE->BLANK, register count into pix_cnt one cycle later.
REQ-010 SHALL set locked on first ACTIVE->BLANK transition; locked stays high until reset.
REQ-011 SHALL increment line_cnt on each ACTIVE->BLANK while locked; wraps modulo 2^PIX_W.
REQ-012 SHALL set err_len when locked and completed line count != EXP_PIX.
REQ-013 H ramp: first DE pixel of each line expected 0, each following pixel previous+1 mod 256.
REQ-014 V ramp: all pixels of a line equal; first line after lock sets reference; each subsequent line expected previous line value+1 mod 256.
REQ-015 SHALL compare d against expectation every DE cycle while locked; mismatch sets err_data on next cycle.
REQ-016 SHALL set err_sync on: hd while de high; de rising in BLANK (DE split); hd in WAIT_DE (empty line).
REQ-017 On hd with de high: FSM SHALL go to WAIT_DE, discard current line count, not update pix_cnt/line_cnt.
REQ-018 err_clr SHALL clear all sticky flags; error event in same cycle as err_clr SHALL win (flag set).
REQ-019 mode_sel change SHALL take effect at next hd; V-ramp reference reloads from the line that follows.
REQ-020 Pixel counter SHALL saturate at 2^PIX_W-1; saturation sets err_len.
REQ-021 Checking of IDLE-period data SHALL be disabled; no errors flagged before locked except err_sync.

Reset
REQ-022 On rstx low, all outputs SHALL be 0 and FSM SHALL be IDLE, asynchronously.
REQ-023 Reset release mid-line SHALL leave the FSM in IDLE until the next hd; partial line SHALL be ignored.

Configuration
REQ-024 Macro STREAM_CHK_ERRCNT_EN defined: SHALL add output err_cnt out 16, saturating count of cycles with any new error event, cleared by err_clr and reset.
REQ-025 Macro absent: err_cnt port and logic SHALL not exist; all other behaviour identical.

Structure
REQ-026 Package stream_chk_pkg SHALL hold FSM state enum, MODE_H_RAMP=1'b0 / MODE_V_RAMP=1'b1 constants.
REQ-027 Sub-module stream_chk_pgen SHALL produce the expected pixel value from mode, hd, de and stored reference.
REQ-028 All registers SHALL be clocked by clk only, reset by rstx only.

Verification
REQ-029 H ramp, EXP_PIX=640, 4 clean lines -> locked=1, pix_cnt=640, line_cnt=4, no error flags.
REQ-030 V ramp, line values 10,11,12 -> no errors; next line value 14 -> err_data=1 one cycle after first pixel.
REQ-031 Line with 639 DE pixels after lock -> err_len=1, pix_cnt=639.
REQ-032 hd asserted during de -> err_sync=1, line_cnt unchanged, next clean line counted normally.
REQ-033 err_clr asserted in same cycle as H-ramp mismatch -> err_data remains 1; err_clr alone next cycle -> 0.
REQ-034 rstx low mid-line then release -> all outputs 0, locked only after next complete hd/de line.
